// File: rtl/fwvip_wb_pkg_hdl.sv
// Shared types and constants for the fwvip Wishbone arbiter.
package fwvip_wb_pkg_hdl;

  localparam int FWVIP_WB_ARB_MAX_INIT = 8;

  typedef enum logic [1:0] {IDLE, BUSY, LOCKED} fwvip_wb_arb_state_e;

  // Width of an initiator index; never zero so N=1 still yields a legal vector.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fwvip_wb_rr_arb.sv
// Rotated priority encoder: one-hot winner is the first requester at or after ptr.
module fwvip_wb_rr_arb
  import fwvip_wb_pkg_hdl::*;
#(
  parameter int N = 2,
  localparam int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win
);

  always_comb begin
    logic          found;
    int            idx;
    logic [PW-1:0] sel;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      sel = PW'(idx);
      if (!found && req[sel]) begin
        win[sel] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwvip_wb_arbiter.sv
// Round-robin Wishbone classic arbiter, N_INIT initiators onto one target.
// Define FWVIP_WB_ARB_LOCK_EN to add i_lock and the LOCKED hold state.
module fwvip_wb_arbiter
  import fwvip_wb_pkg_hdl::*;
#(
  parameter int N_INIT     = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int SW = DATA_WIDTH / 8,
  localparam int PW = ptr_w(N_INIT)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [N_INIT-1:0][ADDR_WIDTH-1:0]    i_adr,
  input  logic [N_INIT-1:0][DATA_WIDTH-1:0]    i_dat_w,
  input  logic [N_INIT-1:0][SW-1:0]            i_sel,
  input  logic [N_INIT-1:0]                    i_we,
  input  logic [N_INIT-1:0]                    i_cyc,
  input  logic [N_INIT-1:0]                    i_stb,
  output logic [N_INIT-1:0][DATA_WIDTH-1:0]    i_dat_r,
  output logic [N_INIT-1:0]                    i_ack,
  output logic [N_INIT-1:0]                    i_err,
`ifdef FWVIP_WB_ARB_LOCK_EN
  input  logic [N_INIT-1:0]                    i_lock,
`endif
  output logic [ADDR_WIDTH-1:0]                t_adr,
  output logic [DATA_WIDTH-1:0]                t_dat_w,
  output logic [SW-1:0]                        t_sel,
  output logic                                 t_we,
  output logic                                 t_cyc,
  output logic                                 t_stb,
  input  logic [DATA_WIDTH-1:0]                t_dat_r,
  input  logic                                 t_ack,
  input  logic                                 t_err,
  output logic [N_INIT-1:0]                    gnt
);

  fwvip_wb_arb_state_e state_q, state_d;
  logic [N_INIT-1:0]   gnt_q, gnt_d, win;
  logic [PW-1:0]       ptr_q, ptr_d, g_idx, ptr_inc;
  logic                owner_cyc, busy;

  fwvip_wb_rr_arb #(.N(N_INIT)) u_rr (
    .req (i_cyc),
    .ptr (ptr_q),
    .win (win)
  );

  always_comb begin
    g_idx = '0;
    for (int k = 0; k < N_INIT; k++)
      if (gnt_q[k]) g_idx = PW'(k);
  end

  assign ptr_inc   = (g_idx == PW'(N_INIT - 1)) ? '0 : g_idx + PW'(1);
  assign owner_cyc = |(i_cyc & gnt_q);
  assign busy      = (state_q == BUSY);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: if (|i_cyc) begin
        state_d = BUSY;
        gnt_d   = win;
      end
      BUSY: if (!owner_cyc) begin
`ifdef FWVIP_WB_ARB_LOCK_EN
        if (|(i_lock & gnt_q)) begin
          state_d = LOCKED;
        end else
`endif
        begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = ptr_inc;
        end
      end
`ifdef FWVIP_WB_ARB_LOCK_EN
      // Owner keeps the bus between cycles of an atomic sequence.
      LOCKED: if (owner_cyc) begin
        state_d = BUSY;
      end else if (!(|(i_lock & gnt_q))) begin
        state_d = IDLE;
        gnt_d   = '0;
        ptr_d   = ptr_inc;
      end
`endif
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt = gnt_q;

  // Request mux: only the granted initiator reaches the target, and only in BUSY.
  always_comb begin
    t_adr   = '0;
    t_dat_w = '0;
    t_sel   = '0;
    t_we    = 1'b0;
    t_cyc   = 1'b0;
    t_stb   = 1'b0;
    if (busy) begin
      for (int k = 0; k < N_INIT; k++) begin
        if (gnt_q[k]) begin
          t_adr   = i_adr[k];
          t_dat_w = i_dat_w[k];
          t_sel   = i_sel[k];
          t_we    = i_we[k];
          t_cyc   = i_cyc[k];
          t_stb   = i_stb[k];
        end
      end
    end
  end

  for (genvar k = 0; k < N_INIT; k++) begin : g_rsp
    wire sel_k = busy & gnt_q[k];
    assign i_ack[k]   = sel_k & t_ack;
    assign i_err[k]   = sel_k & t_err;
    assign i_dat_r[k] = sel_k ? t_dat_r : '0;
  end

endmodule

// File: tb/tb_fwvip_wb_arbiter.sv
// Directed bench for fwvip_wb_arbiter (2 initiators); lock test under FWVIP_WB_ARB_LOCK_EN.
module tb_fwvip_wb_arbiter;
  localparam int N = 2, AW = 32, DW = 32, SW = DW / 8;

  logic                    clock = 1'b0, reset;
  logic [N-1:0][AW-1:0]    i_adr;
  logic [N-1:0][DW-1:0]    i_dat_w, i_dat_r;
  logic [N-1:0][SW-1:0]    i_sel;
  logic [N-1:0]            i_we, i_cyc, i_stb, i_ack, i_err, gnt;
`ifdef FWVIP_WB_ARB_LOCK_EN
  logic [N-1:0]            i_lock;
`endif
  logic [AW-1:0]           t_adr;
  logic [DW-1:0]           t_dat_w, t_dat_r;
  logic [SW-1:0]           t_sel;
  logic                    t_we, t_cyc, t_stb, t_ack, t_err;

  int errors = 0, checks = 0;

  fwvip_wb_arbiter #(.N_INIT(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .i_adr(i_adr), .i_dat_w(i_dat_w), .i_sel(i_sel), .i_we(i_we),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_dat_r(i_dat_r), .i_ack(i_ack), .i_err(i_err),
`ifdef FWVIP_WB_ARB_LOCK_EN
    .i_lock(i_lock),
`endif
    .t_adr(t_adr), .t_dat_w(t_dat_w), .t_sel(t_sel), .t_we(t_we),
    .t_cyc(t_cyc), .t_stb(t_stb), .t_dat_r(t_dat_r), .t_ack(t_ack), .t_err(t_err),
    .gnt(gnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    i_adr = '0; i_dat_w = '0; i_sel = '0; i_we = '0; i_cyc = '0; i_stb = '0;
    t_dat_r = '0; t_ack = 1'b0; t_err = 1'b0;
`ifdef FWVIP_WB_ARB_LOCK_EN
    i_lock = '0;
`endif
    // Reset held with both initiators requesting
    i_cyc = 2'b11; i_stb = 2'b11;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_gnt", gnt, 0);
      chk("rst_tcyc", t_cyc, 0);
      chk("rst_iack", i_ack, 0);
    end
    i_cyc = '0; i_stb = '0;
    reset = 1'b0;
    tick();

    // Single write from i0
    i_adr[0] = 32'h100; i_dat_w[0] = 32'hDEADBEEF; i_sel[0] = 4'hF; i_we[0] = 1'b1;
    i_cyc = 2'b01; i_stb = 2'b01;
    #1 chk("single_tcyc_early", t_cyc, 0);
    tick();
    chk("single_gnt", gnt, 2'b01);
    chk("single_tcyc", t_cyc, 1);
    chk("single_tadr", t_adr, 32'h100);
    chk("single_tdat", t_dat_w, 32'hDEADBEEF);
    chk("single_twe", t_we, 1);
    t_ack = 1'b1;
    #1 chk("single_iack", i_ack, 2'b01);
    tick();
    t_ack = 1'b0; i_cyc = '0; i_stb = '0; i_we = '0;
    #1 chk("single_drop_tcyc", t_cyc, 0);
    tick();
    chk("single_rel_gnt", gnt, 0);

    // Contention from a fresh reset
    reset = 1'b1; tick(); reset = 1'b0;
    i_adr[0] = 32'h200; i_adr[1] = 32'h300;
    i_cyc = 2'b11; i_stb = 2'b11;
    tick();
    chk("cont_gnt0", gnt, 2'b01);
    chk("cont_tadr0", t_adr, 32'h200);
    t_dat_r = 32'hCAFEF00D; t_ack = 1'b1;
    #1 chk("cont_iack0", i_ack, 2'b01);
    chk("cont_rdat0", i_dat_r[0], 32'hCAFEF00D);
    chk("cont_rdat1_zero", i_dat_r[1], 0);
    tick();
    t_ack = 1'b0; i_cyc = 2'b10; i_stb = 2'b10;
    tick();
    chk("cont_dead_gnt", gnt, 0);
    chk("cont_dead_tcyc", t_cyc, 0);
    tick();
    chk("cont_gnt1", gnt, 2'b10);
    chk("cont_tadr1", t_adr, 32'h300);
    t_err = 1'b1;
    #1 chk("cont_ierr1", i_err, 2'b10);
    t_err = 1'b0;
    i_cyc = '0; i_stb = '0;
    tick();
    chk("cont_rel_gnt", gnt, 0);
    i_cyc = 2'b11; i_stb = 2'b11;
    tick();
    chk("rr_back_to_i0", gnt, 2'b01);
    i_cyc = 2'b10; i_stb = 2'b10;
    tick();
    tick();
    chk("rr_then_i1", gnt, 2'b10);
    i_cyc = '0; i_stb = '0;
    tick();

    // Stray target ack while idle
    t_ack = 1'b1;
    #1 chk("stray_iack", i_ack, 0);
    chk("stray_tcyc", t_cyc, 0);
    tick();
    chk("stray_gnt", gnt, 0);
    t_ack = 1'b0;

    // i0 then i1 so pointer sits at 1; reset during i1's read must restore pointer 0
    i_cyc = 2'b01; i_stb = 2'b01;
    tick();
    chk("mid_gnt0", gnt, 2'b01);
    i_cyc = 2'b00; i_stb = 2'b00;
    tick();
    i_cyc = 2'b10; i_stb = 2'b10;
    tick();
    chk("mid_gnt1", gnt, 2'b10);
    t_dat_r = 32'h12345678; t_ack = 1'b1;
    #1 chk("mid_rdat1", i_dat_r[1], 32'h12345678);
    reset = 1'b1;
    tick();
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_tcyc", t_cyc, 0);
    chk("mid_rst_iack", i_ack, 0);
    reset = 1'b0; t_ack = 1'b0;
    i_cyc = 2'b11; i_stb = 2'b11;
    tick();
    chk("mid_rst_ptr0", gnt, 2'b01);
    i_cyc = '0; i_stb = '0;
    tick();
    tick();

`ifdef FWVIP_WB_ARB_LOCK_EN
    // Locked read-modify-write by i0 while i1 waits
    reset = 1'b1; tick(); reset = 1'b0;
    i_cyc = 2'b01; i_stb = 2'b01; i_lock = 2'b01; i_we = 2'b00;
    tick();
    chk("lock_gnt0", gnt, 2'b01);
    t_ack = 1'b1; tick(); t_ack = 1'b0;
    i_cyc = 2'b10; i_stb = 2'b10;
    tick();
    chk("lock_hold_gnt", gnt, 2'b01);
    chk("lock_hold_tcyc", t_cyc, 0);
    tick();
    chk("lock_hold_gnt2", gnt, 2'b01);
    i_cyc = 2'b11; i_stb = 2'b11; i_we = 2'b01;
    tick();
    chk("lock_wr_gnt", gnt, 2'b01);
    chk("lock_wr_twe", t_we, 1);
    t_ack = 1'b1;
    #1 chk("lock_wr_iack", i_ack, 2'b01);
    tick(); t_ack = 1'b0;
    i_cyc = 2'b10; i_stb = 2'b10; i_lock = 2'b00; i_we = '0;
    tick();
    chk("lock_rel_gnt", gnt, 0);
    tick();
    chk("lock_i1_gnt", gnt, 2'b10);
    i_cyc = '0; i_stb = '0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
